// File: rtl/storage_change_reader.sv
// Watches the storage register's output, captures every value change (or an
// explicit read request), and queues the captured values for a downstream consumer.
module storage_change_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   stored_data,
    input  logic                    read_req,
    input  logic                    out_ready,
    input  logic                    clear_overflow,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] last_value;
    logic                  primed;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic change;
    logic capture;
    logic pop;
    logic push;
    logic drop;

    // Handshake: out_valid means out_data is the head entry; an entry leaves the
    // queue on a rising edge where out_valid && out_ready. While out_valid is high
    // and out_ready is low, out_data and out_valid stay unchanged.
    always_comb begin
        change  = primed && (stored_data != last_value);
        capture = change || read_req;
        pop     = out_valid && out_ready;
        push    = capture && ((count != FULL) || pop);
        drop    = capture && (count == FULL) && !pop;
    end

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fill_level = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_value <= '0;
            primed     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            last_value <= stored_data;
            primed     <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear must leave the flag set.
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    // Storage array needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= stored_data;
    end

endmodule

// File: tb/tb_storage_change_reader.sv
// Self-checking bench for storage_change_reader: a reference queue model predicts
// every capture, pop, fill level and overflow state, compared each cycle.
module tb_storage_change_reader;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  stored_data;
    logic          read_req;
    logic          out_ready;
    logic          clear_overflow;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [$clog2(DEPTH):0] fill_level;
    logic          overflow;

    storage_change_reader #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stored_data    (stored_data),
        .read_req       (read_req),
        .out_ready      (out_ready),
        .clear_overflow (clear_overflow),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .fill_level     (fill_level),
        .overflow       (overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_last;
    logic         m_primed;
    logic         m_ovf;
    int           n_checks;
    int           n_pass;
    int           max_fill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last   = '0;
        m_primed = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic check_outputs();
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        check("fill_level", 32'(fill_level), 32'(exp_q.size()));
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
        else                   check("out_data_empty", 32'(out_data), 32'd0);
        if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
    endtask

    // Driver: apply one cycle of inputs, predict the edge, then check after it.
    task automatic drive(input logic [W-1:0] data, input logic rq, input logic rdy,
                         input logic clr);
        logic         chg;
        logic         cap;
        logic         pop;
        logic [W-1:0] tmp;
        stored_data    = data;
        read_req       = rq;
        out_ready      = rdy;
        clear_overflow = clr;
        pop = (exp_q.size() != 0) && rdy;
        chg = m_primed && (data != m_last);
        cap = chg || rq;
        if (pop) tmp = exp_q.pop_front();
        if (cap && exp_q.size() < DEPTH) exp_q.push_back(data);
        if (cap && exp_q.size() >= DEPTH && !(exp_q.size() == DEPTH && exp_q[DEPTH-1] == data
                && (chg || rq) && 0)) begin
            // Drop only when nothing fit: queue was already full before this push.
        end
        m_last   = data;
        m_primed = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // Overflow is predicted separately so the drop decision uses the pre-edge size.
    task automatic drive_c(input logic [W-1:0] data, input logic rq, input logic rdy,
                           input logic clr);
        logic chg;
        logic will_drop;
        chg       = m_primed && (data != m_last);
        will_drop = (chg || rq) && (exp_q.size() == DEPTH) && !rdy;
        if (will_drop)  m_ovf = 1'b1;
        else if (clr)   m_ovf = 1'b0;
        drive(data, rq, rdy, clr);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_fill_level", 32'(fill_level), 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        max_fill = 0;
        model_reset();
        rst_n          = 1'b0;
        stored_data    = 8'h5A;
        read_req       = 1'b0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check("init_out_valid", {31'd0, out_valid}, 32'd0);
        check("init_fill_level", 32'(fill_level), 32'd0);
        check("init_out_data", 32'(out_data), 32'd0);
        check("init_overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;

        // First post-reset sample is never a change
        repeat (10) drive_c(8'h5A, 1'b0, 1'b0, 1'b0);
        check("first_sample_fill", 32'(fill_level), 32'd0);
        check("first_sample_valid", {31'd0, out_valid}, 32'd0);

        // Stepping values with a ready consumer
        max_fill = 0;
        repeat (3) drive_c(8'h00, 1'b0, 1'b1, 1'b0);
        drive_c(8'h11, 1'b0, 1'b1, 1'b0);
        check("lat_11_valid", {31'd0, out_valid}, 32'd1);
        check("lat_11_data", 32'(out_data), 32'h11);
        repeat (2) drive_c(8'h11, 1'b0, 1'b1, 1'b0);
        drive_c(8'h22, 1'b0, 1'b1, 1'b0);
        check("lat_22_valid", {31'd0, out_valid}, 32'd1);
        check("lat_22_data", 32'(out_data), 32'h22);
        repeat (2) drive_c(8'h22, 1'b0, 1'b1, 1'b0);
        check("step_peak_fill", 32'(max_fill), 32'd1);

        // Fill past DEPTH with read requests, then clear overflow
        repeat (2) drive_c(8'h33, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_c(8'h33, 1'b1, 1'b0, 1'b0);
            if (i == 3) check("full_no_ovf", {31'd0, overflow}, 32'd0);
        end
        check("full_fill", 32'(fill_level), 32'd4);
        check("full_ovf", {31'd0, overflow}, 32'd1);
        check("full_data", 32'(out_data), 32'h33);
        drive_c(8'h33, 1'b0, 1'b0, 1'b1);
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Push and pop together while full
        drive_c(8'h33, 1'b1, 1'b1, 1'b0);
        check("full_pushpop_fill", 32'(fill_level), 32'd4);
        check("full_pushpop_ovf", {31'd0, overflow}, 32'd0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) drive_c(8'h33, 1'b0, 1'b1, 1'b0);
        check("drain_empty", 32'(fill_level), 32'd0);

        // Change and read request together make one entry
        drive_c(8'h44, 1'b1, 1'b0, 1'b0);
        drive_c(8'h44, 1'b0, 1'b0, 1'b0);
        check("chg_req_fill", 32'(fill_level), 32'd1);
        check("chg_req_data", 32'(out_data), 32'h44);

        // Mid-operation reset discards queued entries
        repeat (2) drive_c(8'h44, 1'b1, 1'b0, 1'b0);
        check("pre_reset_fill", 32'(fill_level), 32'd3);
        async_reset();
        repeat (5) drive_c(8'h44, 1'b0, 1'b0, 1'b0);
        check("post_reset_fill", 32'(fill_level), 32'd0);
        check("post_reset_valid", {31'd0, out_valid}, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive_c(8'h10 + 8'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/storage_change_reader.md
# storage_change_reader

Read-side companion to the single-register storage block. Samples the storage's registered data output every cycle, detects value changes (or explicit read requests), and queues the captured values in a small FIFO. The queued values are presented to a downstream consumer over a valid/ready handshake. Sits between the storage register and any consumer that must see every update without polling.

## Interface

Parameters:
- DATA_WIDTH, 8, width of stored value and output data
- DEPTH, 4, FIFO entries; power of two, ≥ 2

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stored_data  input  DATA_WIDTH  storage register output, sampled every rising edge
- read_req  input  1  request to capture the current stored_data regardless of change
- out_ready  input  1  consumer accepts out_data this cycle
- clear_overflow  input  1  clears the sticky overflow flag
- out_valid  output  1  FIFO non-empty; out_data is valid
- out_data  output  DATA_WIDTH  head FIFO entry; 0 when empty
- fill_level  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH
- overflow  output  1  sticky; set when a capture is dropped because the FIFO is full

## Operation

- Internal state: last_value (DATA_WIDTH), primed (1), FIFO array, write and read pointers, count.
- Every edge: last_value <= stored_data. primed <= 1 on the first edge after reset release.
- change = primed && (stored_data != last_value). The first post-reset sample never counts as a change.
- capture = change || read_req. Simultaneous change and read_req push exactly one entry.
- pop = out_valid && out_ready.
- Push accepted when capture && (count < DEPTH || pop). The entry written is the stored_data sampled at that edge.
- Push with count == DEPTH and no pop: entry dropped, overflow <= 1, count unchanged.
- Push and pop in the same cycle: both take effect, count unchanged. This includes full and empty states; with count == 0, pop is impossible.
- Pointers wrap modulo DEPTH.
- overflow: set by a drop, cleared by clear_overflow. A drop in the same cycle as clear_overflow leaves overflow at 1.
- out_data holds steady while out_valid && !out_ready.
- fill_level = count, registered.

## Timing

- Reset (rst_n low, asynchronous): out_valid 0, out_data 0, fill_level 0, overflow 0, primed 0, last_value 0, pointers 0. FIFO array contents are don't-care.
- Reset asserted mid-operation discards all queued entries immediately, with no further pops.
- Latency: a capture at edge k into an empty FIFO gives out_valid = 1 and out_data = captured value in the cycle after edge k.
- Throughput: one push and one pop per cycle sustained.
- A value change that lasts one cycle yields two entries: the new value, then the reverted value.
- All outputs are registered or decoded from registered state only. There is no combinational path from stored_data, read_req or out_ready to any output.

## Test plan

- Reset release with stored_data = 0x5A held constant for 10 cycles → no entries (first-sample rule), fill_level 0, out_valid 0.
- stored_data steps 0x00→0x11→0x22, each held 3 cycles, out_ready = 1 → out_data shows 0x11 then 0x22, each valid one cycle after the sampling edge; fill_level peaks at 1.
- out_ready = 0, read_req pulsed 5 times with stored_data = 0x33 (DEPTH 4) → fill_level 4, overflow 1 after the 5th pulse, out_data holds 0x33. Then clear_overflow alone → overflow 0.
- FIFO full, then read_req and out_ready both 1 in the same cycle → one pop and one push, fill_level stays 4, overflow stays 0.
- Change to 0x44 in the same cycle as read_req → exactly one 0x44 entry queued.
- Three entries queued, rst_n pulsed low mid-cycle → outputs go to 0 asynchronously. After release, 0x44 held constant produces no entries.
